nibble_packer: RTL

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_packer.sv | 99 +++++++++
 1 files changed

// File: rtl/nibble_packer.sv
// nibble_packer: packs pairs of accepted 4-bit nibbles into bytes behind a
// single-entry output register. A lone held nibble can be flushed out as a
// zero-padded partial byte. byte_count tracks consumed bytes (mod 256).
module nibble_packer #(
    parameter bit FIRST_IN_MSB = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       flush,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_partial,
    input  logic       out_ready,
    output logic [7:0] byte_count
);

    typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_t;

    state_t     state;
    logic [3:0] held;

    logic slot_free;
    logic accept;
    logic consume;
    logic load_full;
    logic load_part;

    // Handshake qualifiers. In HALF a new byte can only be produced when the
    // output slot is free this cycle; flush wins over a pending nibble.
    always_comb begin
        slot_free = !out_valid || out_ready;
        in_ready  = (state == EMPTY) ? 1'b1 : (slot_free && !flush);
        accept    = in_valid && in_ready;
        consume   = out_valid && out_ready;
        load_full = (state == HALF) && accept;
        load_part = (state == HALF) && flush && slot_free;
    end

    // Pair packing: first nibble lands in the high half when FIRST_IN_MSB.
    function automatic logic [7:0] pack(input logic [3:0] first,
                                        input logic [3:0] second);
        return FIRST_IN_MSB ? {first, second} : {second, first};
    endfunction

    // Nibble holding FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            held  <= 4'h0;
        end else begin
            case (state)
                EMPTY: begin
                    // flush is meaningless with nothing held
                    if (accept) begin
                        held  <= in_data;
                        state <= HALF;
                    end
                end
                HALF: begin
                    if (load_full || load_part)
                        state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Output register: a load in the same cycle as a consume replaces the
    // byte without dropping out_valid, so back-to-back bytes have no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            out_partial <= 1'b0;
        end else if (load_full) begin
            out_valid   <= 1'b1;
            out_data    <= pack(held, in_data);
            out_partial <= 1'b0;
        end else if (load_part) begin
            out_valid   <= 1'b1;
            out_data    <= pack(held, 4'h0);
            out_partial <= 1'b1;
        end else if (consume) begin
            out_valid   <= 1'b0;
        end
    end

    // Consumed-byte counter, partial bytes included; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            byte_count <= 8'h00;
        else if (consume)
            byte_count <= byte_count + 8'd1;
    end

endmodule
